mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified 32-bit memory between the instruction-fetch path (IF, read-only)
//  and the load/store path (LS, read/write) of the RV32I core. Registered FSM front-end:
//  round-robin on contention, holds memory-side signals stable per transaction, and per-transaction
//  timeout with error response. Sits between pc/inst fetch, the data-memory access logic and memory.
// PARAMETERS
//  ADDR_W      32   address width (byte address)
//  DATA_W      32   data width; be width = DATA_W/8
//  TIMEOUT     16   max cycles in BUSY without mem_ack before error completion (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-high
//  if_req     in   1       fetch request; held high with if_addr stable until if_ack
//  if_addr    in   ADDR_W  fetch byte address
//  if_ack     out  1       one-cycle completion pulse to IF
//  if_rdata   out  DATA_W  fetched word, valid while if_ack=1
//  if_err     out  1       timeout flag, valid while if_ack=1
//  ls_req     in   1       load/store request; held high, fields stable, until ls_ack
//  ls_we      in   1       1 = store, 0 = load
//  ls_be      in   DATA_W/8 byte enables for store
//  ls_addr    in   ADDR_W  load/store byte address
//  ls_wdata   in   DATA_W  store data
//  ls_ack     out  1       one-cycle completion pulse to LS
//  ls_rdata   out  DATA_W  load word, valid while ls_ack=1
//  ls_err     out  1       timeout flag, valid while ls_ack=1
//  mem_req    out  1       memory request, held until mem_ack or timeout
//  mem_we     out  1       memory write enable
//  mem_be     out  DATA_W/8 memory byte enables
//  mem_addr   out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_wdata  out  DATA_W  memory write data
//  mem_ack    in   1       memory completion; mem_rdata valid same cycle for reads
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 when state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, last_gnt=LS, all outputs 0, timeout counter 0.
//  - States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if only one req high, grant it; if both, grant the one != last_gnt. On grant: capture
//    owner, addr, we, be, wdata (IF: we=0, be=all 1s); next cycle mem_req=1, state=BUSY,
//    last_gnt=owner, counter=0. No req: stay IDLE.
//  - BUSY: mem_* held constant. mem_ack=1 -> capture mem_rdata (0 for stores), err=0, mem_req=0,
//    go RESP. Else counter++; counter==TIMEOUT-1 without mem_ack -> mem_req=0, rdata=0, err=1,
//    go RESP.
//  - RESP: owner's ack=1 with rdata/err for exactly this cycle; other ack stays 0; go IDLE.
//    Requests ignored in RESP (requester drops/updates req the cycle after its ack).
//  - Latency: req sampled cycle N -> mem_req at N+1 -> mem_ack at N+k (k>=1) -> ack at N+k+1.
//    Min 2 cycles req-to-ack; next grant evaluated at N+k+2.
//  - Fairness: under continuous contention grants alternate IF, LS, IF, ...; first tie after reset
//    goes to IF.
//  - mem_ack in IDLE or RESP is ignored. Timeout and mem_ack in the same cycle: mem_ack wins, err=0.
//  - Input changes while not in IDLE have no effect on mem_* (captured copy used).
//  - rst mid-transaction: next edge forces IDLE, mem_req=0, no ack issued, last_gnt=LS;
//    in-flight transaction discarded.
//  - addr[1:0] dropped on mem_addr; alignment checking is the requester's job.
// TESTING
//  1 IF only: if_addr=0x0000_0010, mem acks 1 cycle after mem_req with 0x0051_3023 ->
//    mem_addr=0x10, mem_we=0, if_ack at cycle 3 with if_rdata=0x0051_3023, if_err=0.
//  2 LS store: ls_addr=0x103, ls_be=4'b0011, ls_wdata=0xDEAD_BEEF -> mem_addr=0x100, mem_we=1,
//    mem_be=0011, ls_ack pulse with ls_rdata=0, ls_err=0.
//  3 Both req from reset, held continuously, mem acks immediately -> grant order IF, LS, IF, LS;
//    no ack pulse longer than 1 cycle; acks never overlap.
//  4 mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then owner ack=1, err=1,
//    rdata=0; FSM back in IDLE.
//  5 rst asserted while BUSY (LS load) -> mem_req=0, busy=0 next cycle, no ls_ack; later mem_ack
//    ignored; a following IF vs LS tie goes to IF.
//  6 ls_addr changed mid-BUSY -> mem_addr unchanged until completion; mem_ack in IDLE produces no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF, read-only)
// and load/store (LS, read/write). IDLE -> BUSY -> RESP FSM with round-robin
// on ties, a captured copy of the winning request driven to memory, and a
// per-transaction timeout that completes the request with an error flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // load/store port
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // registered state and outputs
  state_t              r_state;
  owner_t              r_owner;
  owner_t              r_last_gnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_if_err;
  logic                r_ls_ack;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                r_ls_err;
  logic                r_busy;

  // next-state values
  state_t              w_state_nxt;
  owner_t              w_owner_nxt;
  owner_t              w_last_gnt_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_mem_req_nxt;
  logic                w_mem_we_nxt;
  logic [BE_W-1:0]     w_mem_be_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_if_ack_nxt;
  logic [DATA_W-1:0]   w_if_rdata_nxt;
  logic                w_if_err_nxt;
  logic                w_ls_ack_nxt;
  logic [DATA_W-1:0]   w_ls_rdata_nxt;
  logic                w_ls_err_nxt;

  // arbitration helpers
  logic                w_any_req;
  logic                w_gnt_ls;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_done_rdata;
  logic                w_done;
  logic                w_done_err;

  // LS wins when it is the only requester, or on a tie when IF went last.
  assign w_any_req = if_req | ls_req;
  assign w_gnt_ls  = ls_req & (~if_req | (r_last_gnt == OWN_IF));
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Completion result: mem_ack has priority over the timeout, stores return 0.
  always_comb begin
    w_done       = 1'b0;
    w_done_err   = 1'b0;
    w_done_rdata = '0;
    if (mem_ack) begin
      w_done       = 1'b1;
      w_done_rdata = r_mem_we ? '0 : mem_rdata;
    end else if (w_timeout) begin
      w_done     = 1'b1;
      w_done_err = 1'b1;
    end
  end

  // Next-state and next-output logic; holds everything unless a state acts on it.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_gnt_nxt  = r_last_gnt;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_be_nxt    = r_mem_be;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    // response outputs are single-cycle: cleared unless completing now
    w_if_ack_nxt    = 1'b0;
    w_if_rdata_nxt  = '0;
    w_if_err_nxt    = 1'b0;
    w_ls_ack_nxt    = 1'b0;
    w_ls_rdata_nxt  = '0;
    w_ls_err_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = S_BUSY;
          w_mem_req_nxt  = 1'b1;
          w_cnt_nxt      = '0;
          if (w_gnt_ls) begin
            w_owner_nxt     = OWN_LS;
            w_last_gnt_nxt  = OWN_LS;
            w_mem_we_nxt    = ls_we;
            w_mem_be_nxt    = ls_be;
            w_mem_addr_nxt  = {ls_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata_nxt = ls_wdata;
          end else begin
            w_owner_nxt     = OWN_IF;
            w_last_gnt_nxt  = OWN_IF;
            w_mem_we_nxt    = 1'b0;
            w_mem_be_nxt    = '1;
            w_mem_addr_nxt  = {if_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata_nxt = '0;
          end
        end
      end

      S_BUSY: begin
        if (w_done) begin
          w_state_nxt   = S_RESP;
          w_mem_req_nxt = 1'b0;
          if (r_owner == OWN_LS) begin
            w_ls_ack_nxt   = 1'b1;
            w_ls_rdata_nxt = w_done_rdata;
            w_ls_err_nxt   = w_done_err;
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = w_done_rdata;
            w_if_err_nxt   = w_done_err;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        // ack is visible this cycle; requests are not looked at until IDLE
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_IF;
      r_last_gnt  <= OWN_LS;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_err    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ack    <= w_if_ack_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_if_err    <= w_if_err_nxt;
      r_ls_ack    <= w_ls_ack_nxt;
      r_ls_rdata  <= w_ls_rdata_nxt;
      r_ls_err    <= w_ls_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign ls_ack    = r_ls_ack;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
